// File: rtl/dp_ram_be_if.sv
// Request/response bundle for dp_ram_be: port A read/write with byte enables,
// port B read-only, plus the clear-in-progress indication.
interface dp_ram_be_if #(
  parameter int adr_width = 11,
  parameter int dat_width = 16
) ();
  localparam int nbytes = dat_width / 8;

  logic                 en_a;
  logic                 we_a;
  logic [nbytes-1:0]    be_a;
  logic [adr_width-1:0] adr_a;
  logic [dat_width-1:0] dat_a;
  logic [dat_width-1:0] dat_a_out;
  logic                 valid_a;
  logic                 en_b;
  logic [adr_width-1:0] adr_b;
  logic [dat_width-1:0] dat_b;
  logic                 valid_b;
  logic                 busy;

  modport master (
    output en_a, we_a, be_a, adr_a, dat_a, en_b, adr_b,
    input  dat_a_out, valid_a, dat_b, valid_b, busy
  );

  modport slave (
    input  en_a, we_a, be_a, adr_a, dat_a, en_b, adr_b,
    output dat_a_out, valid_a, dat_b, valid_b, busy
  );
endinterface

// File: rtl/dp_ram_be.sv
// Single-clock dual-port RAM: byte-enabled read/write port A, read-only port B,
// 1- or 2-cycle read latency, selectable collision policy, optional zero-fill after reset.
module dp_ram_be #(
  parameter int    adr_width      = 11,
  parameter int    dat_width      = 16,
  parameter int    rd_latency     = 1,
  parameter bit    rdw_new        = 1'b0,
  parameter bit    clear_on_reset = 1'b1,
  parameter string mem_file_name  = "none"
) (
  input  logic       clk,
  input  logic       rst,
  dp_ram_be_if.slave bus
);
  localparam int depth  = 2 ** adr_width;
  localparam int nbytes = dat_width / 8;
  localparam logic [adr_width-1:0] last_adr = '1;

  typedef enum logic [0:0] {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  if ((rd_latency != 1) && (rd_latency != 2)) begin : g_bad_latency
    $error("dp_ram_be: rd_latency must be 1 or 2");
  end
  if ((dat_width % 8) != 0) begin : g_bad_width
    $error("dp_ram_be: dat_width must be a multiple of 8");
  end

  logic [dat_width-1:0] mem_q [depth];

  state_t               state_q, state_d;
  logic [adr_width-1:0] cnt_q, cnt_d;
  logic                 busy_q;
  logic                 clr_we_s;
  logic                 wr_s, rd_a_s, rd_b_s;
  logic [dat_width-1:0] merged_s, b_word_s;
  logic [dat_width-1:0] ra1_q, rb1_q;
  logic                 va1_q, vb1_q;

  assign wr_s   = !rst && !busy_q && bus.en_a && bus.we_a;
  assign rd_a_s = !rst && !busy_q && bus.en_a && !bus.we_a;
  assign rd_b_s = !rst && !busy_q && bus.en_b;

  // Clear-sequence state and address counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= clear_on_reset ? CLEAR : IDLE;
      cnt_q   <= '0;
      busy_q  <= clear_on_reset;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == CLEAR);
    end
  end

  // Clear-sequence next state: one zero write per cycle until the last word
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_we_s = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we_s = 1'b1;
        cnt_d    = cnt_q + {{(adr_width-1){1'b0}}, 1'b1};
        if (cnt_q == last_adr) begin
          state_d = IDLE;
        end else begin
          state_d = CLEAR;
        end
      end
      IDLE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Word as it will look after this cycle's port A write; feeds the new-data bypass
  always_comb begin
    merged_s = mem_q[bus.adr_a];
    for (int i = 0; i < nbytes; i++) begin
      if (bus.be_a[i]) begin
        merged_s[8*i +: 8] = bus.dat_a[8*i +: 8];
      end else begin
        merged_s[8*i +: 8] = mem_q[bus.adr_a][8*i +: 8];
      end
    end
  end

  // Port B read word, optionally bypassing a same-address write
  always_comb begin
    if (rdw_new && wr_s && (bus.adr_a == bus.adr_b)) begin
      b_word_s = merged_s;
    end else begin
      b_word_s = mem_q[bus.adr_b];
    end
  end

  // Array writes: clear sequence or byte-lane port A write
  always_ff @(posedge clk) begin
    if (!rst && clr_we_s) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_s) begin
      for (int i = 0; i < nbytes; i++) begin
        if (bus.be_a[i]) begin
          mem_q[bus.adr_a][8*i +: 8] <= bus.dat_a[8*i +: 8];
        end
      end
    end
  end

  // First read stage: synchronous array read, data held between reads
  always_ff @(posedge clk) begin
    if (rst) begin
      ra1_q <= '0;
      rb1_q <= '0;
      va1_q <= 1'b0;
      vb1_q <= 1'b0;
    end else begin
      va1_q <= rd_a_s;
      vb1_q <= rd_b_s;
      if (rd_a_s) begin
        ra1_q <= mem_q[bus.adr_a];
      end
      if (rd_b_s) begin
        rb1_q <= b_word_s;
      end
    end
  end

  if (rd_latency == 2) begin : g_lat2
    logic [dat_width-1:0] ra2_q, rb2_q;
    logic                 va2_q, vb2_q;

    // Extra output stage; data only advances alongside its valid
    always_ff @(posedge clk) begin
      if (rst) begin
        ra2_q <= '0;
        rb2_q <= '0;
        va2_q <= 1'b0;
        vb2_q <= 1'b0;
      end else begin
        va2_q <= va1_q;
        vb2_q <= vb1_q;
        if (va1_q) begin
          ra2_q <= ra1_q;
        end
        if (vb1_q) begin
          rb2_q <= rb1_q;
        end
      end
    end

    assign bus.dat_a_out = ra2_q;
    assign bus.valid_a   = va2_q;
    assign bus.dat_b     = rb2_q;
    assign bus.valid_b   = vb2_q;
  end else begin : g_lat1
    assign bus.dat_a_out = ra1_q;
    assign bus.valid_a   = va1_q;
    assign bus.dat_b     = rb1_q;
    assign bus.valid_b   = vb1_q;
  end

  assign bus.busy = busy_q;
endmodule
